// File: rtl/noc_perf_window_monitor.sv
// ----------------------------------------------------------------------------
// noc_perf_window_monitor
//
// Router performance monitor. A bank of EVENT_NUM counters counts 1-bit event
// strobes over a programmable sampling window. At the end of a window, the live
// counts and their sticky overflow flags are copied into a snapshot bank. The
// snapshot bank is read through an indexed port with 1-cycle latency.
//
// Ports
//   clk, rstn        clock; asynchronous active-low reset
//   event_i          per-event increment strobes, sampled every RUN cycle
//   start_i          pulse: begin a window (honoured only in IDLE)
//   stop_i           pulse: end the running window early
//   clear_i          pulse: synchronous clear of counters, snapshots, flags, FSM
//   auto_restart_i   1 = start the next window right after a snapshot
//   win_len_i        window length in cycles, sampled at start (0 acts as 1)
//   rd_req_i         snapshot read request
//   rd_idx_i         snapshot index to read
//   rd_vld_o         read data valid, one cycle after rd_req_i
//   rd_data_o        snapshot count (holds its value when rd_vld_o = 0)
//   rd_ovf_o         snapshot overflow flag (holds its value when rd_vld_o = 0)
//   snap_vld_o       1-cycle pulse in the cycle a new snapshot is written
//   busy_o           window is running
//   win_cnt_o        cycles remaining in the running window (0 otherwise)
// ----------------------------------------------------------------------------
module noc_perf_window_monitor #(
    parameter int EVENT_NUM = 10,
    parameter int CNT_W     = 48,
    parameter int WIN_W     = 16,
    parameter int SAT_EN    = 1,
    parameter int IDX_W     = (EVENT_NUM > 1) ? $clog2(EVENT_NUM) : 1
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic [EVENT_NUM-1:0] event_i,
    input  logic                 start_i,
    input  logic                 stop_i,
    input  logic                 clear_i,
    input  logic                 auto_restart_i,
    input  logic [WIN_W-1:0]     win_len_i,
    input  logic                 rd_req_i,
    input  logic [IDX_W-1:0]     rd_idx_i,
    output logic                 rd_vld_o,
    output logic [CNT_W-1:0]     rd_data_o,
    output logic                 rd_ovf_o,
    output logic                 snap_vld_o,
    output logic                 busy_o,
    output logic [WIN_W-1:0]     win_cnt_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_SNAP = 2'd2
    } state_t;

    state_t                 r_state;
    logic [WIN_W-1:0]       r_win_cnt;
    logic                   r_snap_vld;
    logic [CNT_W-1:0]       r_cnt      [EVENT_NUM];
    logic [EVENT_NUM-1:0]   r_ovf;
    logic [CNT_W-1:0]       r_snap_cnt [EVENT_NUM];
    logic [EVENT_NUM-1:0]   r_snap_ovf;
    logic                   r_rd_vld;
    logic [CNT_W-1:0]       r_rd_data;
    logic                   r_rd_ovf;

    logic [WIN_W-1:0]       w_win_load;
    logic                   w_win_end;
    logic [CNT_W-1:0]       w_cnt_nxt  [EVENT_NUM];
    logic [EVENT_NUM-1:0]   w_ovf_nxt;
    logic [CNT_W-1:0]       w_rd_data;
    logic                   w_rd_ovf;

    // A zero window length still gives a one-cycle window.
    assign w_win_load = (win_len_i == '0) ? WIN_W'(1) : win_len_i;
    // Natural expiry and stop_i on the same cycle collapse into one snapshot.
    assign w_win_end  = stop_i || (r_win_cnt == WIN_W'(1));

    // Per-event next count: saturate or wrap at all-ones, flagging overflow.
    // NOTE: every combinational output gets a default first so that no path
    // leaves it unassigned; a missing default would infer a latch.
    always_comb begin
        for (int k = 0; k < EVENT_NUM; k++) begin
            w_cnt_nxt[k] = r_cnt[k];
            w_ovf_nxt[k] = r_ovf[k];
            if (event_i[k]) begin
                if (&r_cnt[k]) begin
                    w_ovf_nxt[k] = 1'b1;
                    w_cnt_nxt[k] = (SAT_EN != 0) ? r_cnt[k] : '0;
                end else begin
                    w_cnt_nxt[k] = r_cnt[k] + CNT_W'(1);
                end
            end
        end
    end

    // Read mux; indices at or beyond EVENT_NUM fall through to zero.
    always_comb begin
        w_rd_data = '0;
        w_rd_ovf  = 1'b0;
        for (int k = 0; k < EVENT_NUM; k++) begin
            if (rd_idx_i == IDX_W'(k)) begin
                w_rd_data = r_snap_cnt[k];
                w_rd_ovf  = r_snap_ovf[k];
            end
        end
    end

    // Window FSM with live counters and snapshot bank. The snapshot is written
    // on the edge that leaves SNAP, so a read issued during SNAP still sees the
    // previous snapshot.
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state    <= ST_IDLE;
            r_win_cnt  <= '0;
            r_snap_vld <= 1'b0;
            r_ovf      <= '0;
            r_snap_ovf <= '0;
            // NOTE: the snapshot bank is a register file that must read as zero
            // straight out of reset, so it is reset like any other flop
            // rather than left to power-up contents.
            for (int k = 0; k < EVENT_NUM; k++) begin
                r_cnt[k]      <= '0;
                r_snap_cnt[k] <= '0;
            end
        end else if (clear_i) begin
            r_state    <= ST_IDLE;
            r_win_cnt  <= '0;
            r_snap_vld <= 1'b0;
            r_ovf      <= '0;
            r_snap_ovf <= '0;
            for (int k = 0; k < EVENT_NUM; k++) begin
                r_cnt[k]      <= '0;
                r_snap_cnt[k] <= '0;
            end
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    r_snap_vld <= 1'b0;
                    if (start_i) begin
                        r_state   <= ST_RUN;
                        r_win_cnt <= w_win_load;
                        r_ovf     <= '0;
                        for (int k = 0; k < EVENT_NUM; k++) r_cnt[k] <= '0;
                    end
                end
                ST_RUN: begin
                    r_ovf <= w_ovf_nxt;
                    for (int k = 0; k < EVENT_NUM; k++) r_cnt[k] <= w_cnt_nxt[k];
                    if (w_win_end) begin
                        r_state    <= ST_SNAP;
                        r_win_cnt  <= '0;
                        r_snap_vld <= 1'b1;
                    end else begin
                        r_win_cnt  <= r_win_cnt - WIN_W'(1);
                    end
                end
                ST_SNAP: begin
                    r_snap_vld <= 1'b0;
                    r_snap_ovf <= r_ovf;
                    for (int k = 0; k < EVENT_NUM; k++) r_snap_cnt[k] <= r_cnt[k];
                    if (auto_restart_i) begin
                        r_state   <= ST_RUN;
                        r_win_cnt <= w_win_load;
                        r_ovf     <= '0;
                        for (int k = 0; k < EVENT_NUM; k++) r_cnt[k] <= '0;
                    end else begin
                        r_state   <= ST_IDLE;
                    end
                end
                default: begin
                    r_state    <= ST_IDLE;
                    r_win_cnt  <= '0;
                    r_snap_vld <= 1'b0;
                end
            endcase
        end
    end

    // Read port: one request per cycle, one-cycle latency. A read that
    // coincides with clear_i returns the post-clear value of zero.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_rd_vld  <= 1'b0;
            r_rd_data <= '0;
            r_rd_ovf  <= 1'b0;
        end else begin
            r_rd_vld <= rd_req_i;
            if (rd_req_i) begin
                r_rd_data <= clear_i ? '0 : w_rd_data;
                r_rd_ovf  <= clear_i ? 1'b0 : w_rd_ovf;
            end
        end
    end

    assign rd_vld_o   = r_rd_vld;
    assign rd_data_o  = r_rd_data;
    assign rd_ovf_o   = r_rd_ovf;
    assign snap_vld_o = r_snap_vld;
    assign busy_o     = (r_state == ST_RUN);
    assign win_cnt_o  = r_win_cnt;

endmodule

// File: tb/tb_noc_perf_window_monitor.sv
// ----------------------------------------------------------------------------
// Directed bench for noc_perf_window_monitor. Three instances share all
// inputs: a default-width saturating monitor, a 4-bit saturating monitor and
// a 4-bit wrapping monitor. Inputs change 1 ns after the rising edge, and
// outputs are sampled 1 ns after the rising edge.
// ----------------------------------------------------------------------------
module tb_noc_perf_window_monitor;

    localparam int EN = 10;
    localparam int WW = 16;
    localparam int IW = 4;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic [EN-1:0] event_i = '0;
    logic          start_i = 1'b0;
    logic          stop_i = 1'b0;
    logic          clear_i = 1'b0;
    logic          auto_restart_i = 1'b0;
    logic [WW-1:0] win_len_i = '0;
    logic          rd_req_i = 1'b0;
    logic [IW-1:0] rd_idx_i = '0;

    logic          m_rd_vld, m_rd_ovf, m_snap, m_busy;
    logic [47:0]   m_rd_data;
    logic [WW-1:0] m_win;
    logic          s_rd_vld, s_rd_ovf, s_snap, s_busy;
    logic [3:0]    s_rd_data;
    logic [WW-1:0] s_win;
    logic          w_rd_vld, w_rd_ovf, w_snap, w_busy;
    logic [3:0]    w_rd_data;
    logic [WW-1:0] w_win;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    noc_perf_window_monitor #(.EVENT_NUM(EN), .CNT_W(48), .WIN_W(WW), .SAT_EN(1)) u_main (
        .clk(clk), .rstn(rstn), .event_i(event_i), .start_i(start_i), .stop_i(stop_i),
        .clear_i(clear_i), .auto_restart_i(auto_restart_i), .win_len_i(win_len_i),
        .rd_req_i(rd_req_i), .rd_idx_i(rd_idx_i), .rd_vld_o(m_rd_vld), .rd_data_o(m_rd_data),
        .rd_ovf_o(m_rd_ovf), .snap_vld_o(m_snap), .busy_o(m_busy), .win_cnt_o(m_win)
    );

    noc_perf_window_monitor #(.EVENT_NUM(EN), .CNT_W(4), .WIN_W(WW), .SAT_EN(1)) u_sat (
        .clk(clk), .rstn(rstn), .event_i(event_i), .start_i(start_i), .stop_i(stop_i),
        .clear_i(clear_i), .auto_restart_i(auto_restart_i), .win_len_i(win_len_i),
        .rd_req_i(rd_req_i), .rd_idx_i(rd_idx_i), .rd_vld_o(s_rd_vld), .rd_data_o(s_rd_data),
        .rd_ovf_o(s_rd_ovf), .snap_vld_o(s_snap), .busy_o(s_busy), .win_cnt_o(s_win)
    );

    noc_perf_window_monitor #(.EVENT_NUM(EN), .CNT_W(4), .WIN_W(WW), .SAT_EN(0)) u_wrap (
        .clk(clk), .rstn(rstn), .event_i(event_i), .start_i(start_i), .stop_i(stop_i),
        .clear_i(clear_i), .auto_restart_i(auto_restart_i), .win_len_i(win_len_i),
        .rd_req_i(rd_req_i), .rd_idx_i(rd_idx_i), .rd_vld_o(w_rd_vld), .rd_data_o(w_rd_data),
        .rd_ovf_o(w_rd_ovf), .snap_vld_o(w_snap), .busy_o(w_busy), .win_cnt_o(w_win)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue a one-cycle read on all instances and check the main instance.
    task automatic read_main(input string tag, input int idx, input logic [63:0] exp_d,
                             input logic exp_o);
        rd_req_i = 1'b1;
        rd_idx_i = IW'(idx);
        tick();
        check({tag, "_vld"}, 64'(m_rd_vld), 64'd1);
        check({tag, "_data"}, 64'(m_rd_data), exp_d);
        check({tag, "_ovf"}, 64'(m_rd_ovf), 64'(exp_o));
    endtask

    initial begin
        // ---------------- reset ----------------
        tick();
        tick();
        rstn = 1'b1;
        check("rst_busy", 64'(m_busy), 64'd0);
        check("rst_win", 64'(m_win), 64'd0);
        check("rst_snap", 64'(m_snap), 64'd0);
        check("rst_rd_vld", 64'(m_rd_vld), 64'd0);
        check("rst_rd_data", 64'(m_rd_data), 64'd0);
        check("rst_rd_ovf", 64'(m_rd_ovf), 64'd0);

        // ---------------- async reset mid-RUN ----------------
        event_i   = 10'b0000000001;
        win_len_i = 16'd20;
        start_i   = 1'b1;
        tick();
        start_i = 1'b0;
        check("mid_busy", 64'(m_busy), 64'd1);
        check("mid_win0", 64'(m_win), 64'd20);
        tick();
        tick();
        check("mid_win2", 64'(m_win), 64'd18);
        rd_req_i = 1'b1;
        tick();
        rd_req_i = 1'b0;
        check("mid_rdvld", 64'(m_rd_vld), 64'd1);
        #2 rstn = 1'b0;
        #1;
        check("arst_busy", 64'(m_busy), 64'd0);
        check("arst_win", 64'(m_win), 64'd0);
        check("arst_snap", 64'(m_snap), 64'd0);
        check("arst_rd_vld", 64'(m_rd_vld), 64'd0);
        #2 rstn = 1'b1;
        event_i = '0;
        tick();
        for (int i = 0; i < EN; i++) read_main("arst_rd", i, 64'd0, 1'b0);
        rd_req_i = 1'b0;

        // ---------------- basic window: len 8 ----------------
        win_len_i = 16'd8;
        start_i   = 1'b1;
        tick();
        start_i = 1'b0;
        check("bas_win8", 64'(m_win), 64'd8);
        for (int r = 1; r <= 8; r++) begin
            event_i = 10'b0000000100 | ((r == 2 || r == 4 || r == 6) ? 10'b1 : 10'b0);
            tick();
            if (r == 7) begin
                check("bas_win1", 64'(m_win), 64'd1);
                check("bas_nosnap", 64'(m_snap), 64'd0);
            end
        end
        check("bas_snap", 64'(m_snap), 64'd1);
        check("bas_snap_busy", 64'(m_busy), 64'd0);
        check("bas_snap_win", 64'(m_win), 64'd0);
        // Read during SNAP sees the previous snapshot; SNAP events are ignored.
        event_i = '1;
        read_main("bas_rd_insnap", 2, 64'd0, 1'b0);
        check("bas_snap_end", 64'(m_snap), 64'd0);
        event_i = '0;
        read_main("bas_rd2", 2, 64'd8, 1'b0);
        read_main("bas_rd0", 0, 64'd3, 1'b0);
        read_main("bas_rd7", 7, 64'd0, 1'b0);
        read_main("bas_rd15", 15, 64'd0, 1'b0);
        read_main("bas_rd0b", 0, 64'd3, 1'b0);
        rd_req_i = 1'b0;
        tick();
        check("bas_rd_idle_vld", 64'(m_rd_vld), 64'd0);
        check("bas_rd_hold", 64'(m_rd_data), 64'd3);

        // ---------------- early stop ----------------
        event_i   = 10'b0000000010;
        win_len_i = 16'd100;
        start_i   = 1'b1;
        tick();
        start_i = 1'b0;
        check("stp_win", 64'(m_win), 64'd100);
        for (int r = 1; r <= 5; r++) begin
            stop_i = (r == 5);
            tick();
            if (r == 4) check("stp_win96", 64'(m_win), 64'd96);
        end
        stop_i = 1'b0;
        check("stp_snap", 64'(m_snap), 64'd1);
        event_i = '0;
        tick();
        check("stp_snap_off", 64'(m_snap), 64'd0);
        check("stp_idle", 64'(m_busy), 64'd0);
        tick();
        check("stp_single", 64'(m_snap), 64'd0);
        read_main("stp_rd1", 1, 64'd5, 1'b0);
        read_main("stp_rd2", 2, 64'd0, 1'b0);
        rd_req_i = 1'b0;

        // ---------------- saturate / wrap: 20 events on ch3 ----------------
        event_i   = 10'b0000001000;
        win_len_i = 16'd20;
        start_i   = 1'b1;
        tick();
        start_i = 1'b0;
        repeat (20) tick();
        check("sat_snap_m", 64'(m_snap), 64'd1);
        check("sat_snap_s", 64'(s_snap), 64'd1);
        check("sat_snap_w", 64'(w_snap), 64'd1);
        event_i = '0;
        tick();
        rd_req_i = 1'b1;
        rd_idx_i = IW'(3);
        tick();
        rd_req_i = 1'b0;
        check("sat_m_data", 64'(m_rd_data), 64'd20);
        check("sat_m_ovf", 64'(m_rd_ovf), 64'd0);
        check("sat_s_data", 64'(s_rd_data), 64'd15);
        check("sat_s_ovf", 64'(s_rd_ovf), 64'd1);
        check("wrp_w_data", 64'(w_rd_data), 64'd4);
        check("wrp_w_ovf", 64'(w_rd_ovf), 64'd1);
        // Quiet window; stop_i coincides with natural expiry.
        win_len_i = 16'd3;
        start_i   = 1'b1;
        tick();
        start_i = 1'b0;
        tick();
        tick();
        check("col_win1", 64'(m_win), 64'd1);
        stop_i = 1'b1;
        tick();
        stop_i = 1'b0;
        check("col_snap", 64'(m_snap), 64'd1);
        tick();
        check("col_snap_off", 64'(m_snap), 64'd0);
        tick();
        check("col_single", 64'(m_snap), 64'd0);
        rd_req_i = 1'b1;
        rd_idx_i = IW'(3);
        tick();
        rd_req_i = 1'b0;
        check("qt_m_data", 64'(m_rd_data), 64'd0);
        check("qt_s_data", 64'(s_rd_data), 64'd0);
        check("qt_s_ovf", 64'(s_rd_ovf), 64'd0);
        check("qt_w_data", 64'(w_rd_data), 64'd0);
        check("qt_w_ovf", 64'(w_rd_ovf), 64'd0);

        // ---------------- auto-restart: len 4, ch0 constant ----------------
        auto_restart_i = 1'b1;
        event_i        = 10'b0000000001;
        win_len_i      = 16'd4;
        start_i        = 1'b1;
        tick();
        start_i = 1'b0;
        repeat (3) tick();
        check("ar_pre_snap", 64'(m_snap), 64'd0);
        tick();
        check("ar_snap1", 64'(m_snap), 64'd1);
        read_main("ar_rd_insnap", 0, 64'd0, 1'b0);
        check("ar_restart_busy", 64'(m_busy), 64'd1);
        check("ar_restart_win", 64'(m_win), 64'd4);
        check("ar_restart_snap", 64'(m_snap), 64'd0);
        read_main("ar_rd_after", 0, 64'd4, 1'b0);
        rd_req_i = 1'b0;
        tick();
        check("ar_c3", 64'(m_snap), 64'd0);
        tick();
        check("ar_c4", 64'(m_snap), 64'd0);
        tick();
        check("ar_snap2", 64'(m_snap), 64'd1);
        auto_restart_i = 1'b0;
        event_i        = '0;
        tick();
        check("ar_idle", 64'(m_busy), 64'd0);
        read_main("ar_rd2", 0, 64'd4, 1'b0);
        rd_req_i = 1'b0;

        // ---------------- clear together with expiry ----------------
        event_i   = 10'b0000010000;
        win_len_i = 16'd2;
        start_i   = 1'b1;
        tick();
        start_i = 1'b0;
        tick();
        check("clr_win1", 64'(m_win), 64'd1);
        clear_i  = 1'b1;
        rd_req_i = 1'b1;
        rd_idx_i = IW'(0);
        tick();
        clear_i = 1'b0;
        event_i = '0;
        check("clr_nosnap", 64'(m_snap), 64'd0);
        check("clr_busy", 64'(m_busy), 64'd0);
        check("clr_win", 64'(m_win), 64'd0);
        check("clr_rd_vld", 64'(m_rd_vld), 64'd1);
        check("clr_rd_data", 64'(m_rd_data), 64'd0);
        read_main("clr_rd4", 4, 64'd0, 1'b0);
        read_main("clr_rd0", 0, 64'd0, 1'b0);
        rd_req_i = 1'b0;
        tick();
        check("clr_nosnap2", 64'(m_snap), 64'd0);

        // ---------------- start while RUN ignored ----------------
        win_len_i = 16'd6;
        start_i   = 1'b1;
        tick();
        win_len_i = 16'd50;
        tick();
        check("sir_win5", 64'(m_win), 64'd5);
        tick();
        check("sir_win4", 64'(m_win), 64'd4);
        start_i = 1'b0;
        repeat (3) tick();
        check("sir_win1", 64'(m_win), 64'd1);
        tick();
        check("sir_snap", 64'(m_snap), 64'd1);

        // ---------------- start in SNAP ignored, then win_len 0 ----------------
        start_i   = 1'b1;
        win_len_i = 16'd0;
        tick();
        check("sis_idle", 64'(m_busy), 64'd0);
        tick();
        start_i = 1'b0;
        event_i = 10'b0000100000;
        check("wl0_busy", 64'(m_busy), 64'd1);
        check("wl0_win", 64'(m_win), 64'd1);
        tick();
        event_i = '0;
        check("wl0_snap", 64'(m_snap), 64'd1);
        tick();
        read_main("wl0_rd5", 5, 64'd1, 1'b0);
        rd_req_i = 1'b0;

        // ---------------- stop in IDLE ignored ----------------
        stop_i = 1'b1;
        tick();
        stop_i = 1'b0;
        check("sti_snap", 64'(m_snap), 64'd0);
        check("sti_busy", 64'(m_busy), 64'd0);
        tick();
        check("sti_snap2", 64'(m_snap), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
